instr_fetch_unit: RTL and testbench

// - Fetch stage upstream of the single-cycle execute core: owns the PC, issues word reads to

---
 rtl/instr_fetch_unit_pkg.sv | 12 +
 rtl/instr_fetch_unit_fetch_fifo.sv | 82 ++++++++
 rtl/instr_fetch_unit.sv | 118 +++++++++++
 tb/tb_instr_fetch_unit.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants for the instruction fetch unit: default widths, reset PC,
// prefetch queue depth and the fetch stride.
package instr_fetch_unit_pkg;

    localparam int unsigned IFU_ADDR_W     = 32;
    localparam int unsigned IFU_DATA_W     = 32;
    localparam int unsigned IFU_FIFO_DEPTH = 4;
    localparam int unsigned IFU_WORD_BYTES = 4;

    localparam logic [IFU_ADDR_W-1:0] IFU_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Prefetch queue for the fetch unit: synchronous FIFO of {instr, pc} entries.
// Ports:
//   clock, reset      - clock and synchronous active-low reset
//   push, push_data   - enqueue an entry (ignored when full unless popping)
//   pop               - dequeue the head (ignored when empty)
//   flush             - drop all entries; a same-cycle pop still retires first
//   count             - current occupancy (0..DEPTH)
//   head              - entry at the read pointer
module instr_fetch_unit_fetch_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned WIDTH = IFU_DATA_W + IFU_ADDR_W,
    parameter int unsigned DEPTH = IFU_FIFO_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Next-state: pop retires before flush; flush wins over push.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (flush) begin
            wr_ptr_d = rd_ptr_d;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage is cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clock) begin
        if (!reset) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues word reads to instruction memory
// (fixed 1-cycle read latency), buffers returned words in a prefetch queue and
// presents {instr, instr_pc} over valid/ready. A redirect flushes the queue and
// drops any response still in flight.
// Ports:
//   clock, reset                  - clock and synchronous active-low reset
//   imem_req, imem_addr           - read request / word-aligned address
//   imem_rvalid, imem_rdata       - read response (one cycle after request)
//   instr_valid, instr_ready      - queue head handshake
//   instr, instr_pc               - queue head word and its address
//   redirect_valid, redirect_pc   - PC change from execute
//   redirect_misal                - one-cycle pulse for a misaligned redirect target
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned          ADDR_W     = IFU_ADDR_W,
    parameter int unsigned          DATA_W     = IFU_DATA_W,
    parameter logic [ADDR_W-1:0]    RESET_PC   = ADDR_W'(IFU_RESET_PC),
    parameter int unsigned          FIFO_DEPTH = IFU_FIFO_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              redirect_misal
);

    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned ENTRY_W = DATA_W + ADDR_W;

    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  resp_pc_q, resp_pc_d;
    logic               inflight_q, inflight_d;
    logic               discard_q, discard_d;
    logic               misal_q, misal_d;

    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] fifo_head;
    logic               issue_c;
    logic               push_c;
    logic               pop_c;

    // Credit check counts the in-flight word so a response always has a slot.
    // Deliberately independent of instr_ready.
    assign issue_c = reset && !redirect_valid &&
                     ((fifo_count + CNT_W'(inflight_q)) < CNT_W'(FIFO_DEPTH));

    assign push_c = imem_rvalid && !discard_q && !redirect_valid;
    assign pop_c  = instr_valid && instr_ready;

    // PC, response tracking, discard and misalign pulse next-state.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = issue_c;
        discard_d  = 1'b0;
        misal_d    = 1'b0;

        if (issue_c) begin
            resp_pc_d = fetch_pc_q;
        end

        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
            discard_d  = inflight_q;
            misal_d    = (redirect_pc[1:0] != 2'b00);
        end else if (issue_c) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(IFU_WORD_BYTES);
        end
    end

    // Reset sets discard so a response landing right after release is dropped.
    always_ff @(posedge clock) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= '0;
            inflight_q <= 1'b0;
            discard_q  <= 1'b1;
            misal_q    <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            misal_q    <= misal_d;
        end
    end

    instr_fetch_unit_fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_c),
        .push_data ({imem_rdata, resp_pc_q}),
        .pop       (pop_c),
        .flush     (redirect_valid),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign imem_req       = issue_c;
    assign imem_addr      = fetch_pc_q;
    assign instr_valid    = (fifo_count != '0);
    assign instr          = fifo_head[ENTRY_W-1:ADDR_W];
    assign instr_pc       = fifo_head[ADDR_W-1:0];
    assign redirect_misal = misal_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit. Stimulus pushes the expected
// {instr, pc} stream into a queue; a monitor pops and compares on every
// accepted handshake. A second instance covers PC wrap-around.
module tb_instr_fetch_unit;

    localparam logic [31:0] MASK  = 32'hA5A5_0000;
    localparam logic [31:0] STALE = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } item_t;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_misal;
    logic        inject;

    logic        reset2;
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic        imem_rvalid2;
    logic [31:0] imem_rdata2;
    logic        instr_valid2;
    logic        ready2;
    logic [31:0] instr2;
    logic [31:0] instr_pc2;
    logic        redirect_misal2;

    item_t exp_q[$];
    item_t exp2_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    instr_fetch_unit dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_misal (redirect_misal)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clock          (clock),
        .reset          (reset2),
        .imem_req       (imem_req2),
        .imem_addr      (imem_addr2),
        .imem_rvalid    (imem_rvalid2),
        .imem_rdata     (imem_rdata2),
        .instr_valid    (instr_valid2),
        .instr_ready    (ready2),
        .instr          (instr2),
        .instr_pc       (instr_pc2),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .redirect_misal (redirect_misal2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instruction memory models: 1-cycle latency, data = addr ^ MASK.
    // inject forces a stale response to land in the next cycle.
    always @(posedge clock) begin
        imem_rvalid  <= imem_req | inject;
        imem_rdata   <= inject ? STALE : (imem_addr ^ MASK);
        imem_rvalid2 <= imem_req2;
        imem_rdata2  <= imem_addr2 ^ MASK;
    end

    function automatic item_t mk(input logic [31:0] pc);
        item_t it;
        it.instr = pc ^ MASK;
        it.pc    = pc;
        return it;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(mk(start + 32'(4 * i)));
    endtask

    // Main monitor: every accepted head must match the next expected entry.
    always @(negedge clock) begin
        if (reset && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_instr: got pc %h, expected no delivery (t=%0t)", instr_pc, $time);
            end else begin
                item_t e;
                e = exp_q.pop_front();
                check32("instr_pc", instr_pc, e.pc);
                check32("instr", instr, e.instr);
            end
        end
    end

    // Wrap-around monitor: compares the first deliveries after release.
    always @(negedge clock) begin
        if (reset2 && instr_valid2 && ready2 && exp2_q.size() > 0) begin
            item_t e;
            e = exp2_q.pop_front();
            check32("wrap_instr_pc", instr_pc2, e.pc);
            check32("wrap_instr", instr2, e.instr);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned nreq;
        reset          = 1'b0;
        reset2         = 1'b0;
        instr_ready    = 1'b1;
        ready2         = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inject         = 1'b0;
        exp2_q.push_back(mk(32'hFFFF_FFF8));
        exp2_q.push_back(mk(32'hFFFF_FFFC));
        exp2_q.push_back(mk(32'h0000_0000));
        exp2_q.push_back(mk(32'h0000_0004));
        exp2_q.push_back(mk(32'h0000_0008));

        // Reset state
        step();
        @(negedge clock);
        check32("rst_imem_req", 32'(imem_req), 32'd0);
        check32("rst_imem_addr", imem_addr, 32'h0);
        check32("rst_instr_valid", 32'(instr_valid), 32'd0);
        check32("rst_instr", instr, 32'h0);
        check32("rst_instr_pc", instr_pc, 32'h0);
        check32("rst_misal", 32'(redirect_misal), 32'd0);
        step();
        inject = 1'b1;
        step();

        // Release with ready high: latency 2, one per cycle
        reset  = 1'b1;
        reset2 = 1'b1;
        inject = 1'b0;
        push_seq(32'h0, 4);
        @(negedge clock);
        check32("k0_imem_req", 32'(imem_req), 32'd1);
        check32("k0_imem_addr", imem_addr, 32'h0);
        check32("k0_instr_valid", 32'(instr_valid), 32'd0);
        step();
        @(negedge clock);
        check32("k1_instr_valid", 32'(instr_valid), 32'd0);
        check32("k1_imem_addr", imem_addr, 32'h4);
        for (int k = 2; k < 5; k++) begin
            step();
            @(negedge clock);
            check32("stream_valid", 32'(instr_valid), 32'd1);
        end

        // Aligned redirect with one response in flight
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        push_seq(32'h100, 4);
        @(negedge clock);
        check32("redir_imem_req", 32'(imem_req), 32'd0);
        step();
        redirect_valid = 1'b0;
        @(negedge clock);
        check32("redir1_imem_req", 32'(imem_req), 32'd1);
        check32("redir1_imem_addr", imem_addr, 32'h100);
        check32("redir1_instr_valid", 32'(instr_valid), 32'd0);
        check32("redir1_misal", 32'(redirect_misal), 32'd0);
        step();
        @(negedge clock);
        check32("redir2_instr_valid", 32'(instr_valid), 32'd0);
        step();
        @(negedge clock);
        check32("redir3_instr_valid", 32'(instr_valid), 32'd1);
        step();
        step();

        // Misaligned redirect
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        push_seq(32'h100, 8);
        @(negedge clock);
        check32("misal_req_in_R", 32'(imem_req), 32'd0);
        step();
        redirect_valid = 1'b0;
        @(negedge clock);
        check32("misal_pulse", 32'(redirect_misal), 32'd1);
        check32("misal_imem_req", 32'(imem_req), 32'd1);
        check32("misal_imem_addr", imem_addr, 32'h100);
        step();
        @(negedge clock);
        check32("misal_pulse_end", 32'(redirect_misal), 32'd0);
        check32("misal_instr_valid", 32'(instr_valid), 32'd0);
        for (int k = 2; k < 10; k++) step();

        // Reset with ready low, then fill test from reset
        step();
        reset       = 1'b0;
        instr_ready = 1'b0;
        check32("pre_reset_exp_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clock);
        check32("rstA_imem_req", 32'(imem_req), 32'd0);
        step();
        inject = 1'b1;
        @(negedge clock);
        check32("rstB_instr_valid", 32'(instr_valid), 32'd0);
        check32("rstB_instr", instr, 32'h0);
        check32("rstB_imem_addr", imem_addr, 32'h0);
        step();
        reset  = 1'b1;
        inject = 1'b0;
        push_seq(32'h0, 10);
        nreq = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (imem_req) begin
                check32("fill_addr", imem_addr, 32'(4 * nreq));
                nreq++;
            end
            if (k == 9) begin
                check32("full_imem_req", 32'(imem_req), 32'd0);
                check32("full_instr_valid", 32'(instr_valid), 32'd1);
                check32("full_instr_pc", instr_pc, 32'h0);
                check32("full_instr", instr, MASK);
            end
            step();
        end
        check32("fill_req_count", 32'(nreq), 32'd4);

        // Drain: no request in the first ready cycle, resume at 16
        instr_ready = 1'b1;
        @(negedge clock);
        check32("drain0_imem_req", 32'(imem_req), 32'd0);
        step();
        @(negedge clock);
        check32("drain1_imem_req", 32'(imem_req), 32'd1);
        check32("drain1_imem_addr", imem_addr, 32'h10);
        for (int k = 11; k < 20; k++) step();

        // Refill, then reset mid-stream with queue full
        instr_ready = 1'b0;
        for (int k = 20; k < 25; k++) step();
        @(negedge clock);
        check32("refill_instr_valid", 32'(instr_valid), 32'd1);
        check32("refill_imem_req", 32'(imem_req), 32'd0);
        step();
        reset = 1'b0;
        check32("drain_exp_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clock);
        check32("midrst_imem_req", 32'(imem_req), 32'd0);
        step();
        inject = 1'b1;
        @(negedge clock);
        check32("midrst_instr_valid", 32'(instr_valid), 32'd0);
        check32("midrst2_imem_req", 32'(imem_req), 32'd0);
        step();
        reset       = 1'b1;
        inject      = 1'b0;
        instr_ready = 1'b1;
        push_seq(32'h0, 6);
        @(negedge clock);
        check32("restart_imem_req", 32'(imem_req), 32'd1);
        check32("restart_imem_addr", imem_addr, 32'h0);
        step();
        @(negedge clock);
        check32("stale_dropped_valid", 32'(instr_valid), 32'd0);
        step();
        @(negedge clock);
        check32("restart_valid", 32'(instr_valid), 32'd1);
        for (int k = 3; k < 8; k++) step();
        step();
        instr_ready = 1'b0;
        step();

        check32("final_exp_left", 32'(exp_q.size()), 32'd0);
        check32("wrap_exp_left", 32'(exp2_q.size()), 32'd0);
        check32("wrap_misal", 32'(redirect_misal2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
